// File: rtl/axis_m.sv
// AXI4-Stream master adapter: internal valid/ready beats are buffered in a
// first-word-fall-through FIFO and presented on an AXIS master port.
module axis_m #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       last_in,
    output logic                       ready_out,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       pkt_sent
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // ready_out comes from registered occupancy only, so there is no
    // combinational path from m_axis_tready back to the internal source.
    assign ready_out     = ~full;
    assign m_axis_tvalid = ~empty;
    assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];

    assign push = valid_in & ready_out;
    assign pop  = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= {last_in, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pkt_sent <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            pkt_sent <= pop & m_axis_tlast;
        end
    end

endmodule

// File: tb/tb_axis_m.sv
// Scoreboard bench for axis_m: a queue model of the FIFO predicts occupancy,
// output beats and packet pulses; directed phases plus a randomized stall phase.
module tb_axis_m;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          last_in = 1'b0;
    logic          ready_out;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [CW-1:0] count;
    logic          pkt_sent;

    axis_m #(.WIDTH(W), .DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .last_in       (last_in),
        .ready_out     (ready_out),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .count         (count),
        .pkt_sent      (pkt_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    beat_t      sb_q[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic       exp_pkt = 1'b0;
    bit         stall_prev = 1'b0;
    logic [W:0] held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT against the queue model, then advances the model
    // by what the coming rising edge will do.
    always @(negedge clk) begin : mon
        int   n;
        logic push;
        if (mon_en) begin
            n = sb_q.size();
            chk("count", 64'(count), 64'(n));
            chk("ready_out", 64'(ready_out), 64'(n < D));
            chk("tvalid", 64'(m_axis_tvalid), 64'(n > 0));
            chk("pkt_sent", 64'(pkt_sent), 64'(exp_pkt));
            if (stall_prev)
                chk("stable", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'({1'b1, held}));
            if (n > 0 && m_axis_tvalid) begin
                chk("tdata", 64'(m_axis_tdata), 64'(sb_q[0].d));
                chk("tlast", 64'(m_axis_tlast), 64'(sb_q[0].l));
            end
            if (rst) begin
                sb_q.delete();
                exp_pkt    = 1'b0;
                stall_prev = 1'b0;
            end else begin
                exp_pkt    = 1'b0;
                stall_prev = m_axis_tvalid && !m_axis_tready;
                held       = {m_axis_tlast, m_axis_tdata};
                push       = valid_in && (n < D);
                if (n > 0 && m_axis_tready) begin
                    exp_pkt = sb_q[0].l;
                    void'(sb_q.pop_front());
                end
                if (push) sb_q.push_back('{data_in, last_in});
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        @(posedge clk);
        #1;
        valid_in      = v;
        data_in       = d;
        last_in       = l;
        m_axis_tready = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset then idle with tready high
        @(negedge clk);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset_ready", 64'(ready_out), 64'd1);
        repeat (3) drive(1'b0, '0, 1'b0, 1'b1);

        // Single beat
        drive(1'b1, 32'hA5A5_0001, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        chk("single_tdata", 64'(m_axis_tdata), 64'hA5A5_0001);
        repeat (3) drive(1'b0, '0, 1'b0, 1'b1);

        // Backpressure and fill, fifth push dropped
        for (int i = 0; i < 5; i++) drive(1'b1, W'(32'h10 + i), 1'b0, 1'b0);
        @(negedge clk);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_ready", 64'(ready_out), 64'd0);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("fill_head", 64'(m_axis_tdata), 64'h10);
        repeat (6) drive(1'b0, '0, 1'b0, 1'b1);

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) drive(1'b1, W'(i), (i == 9), 1'b1);
        repeat (3) drive(1'b0, '0, 1'b0, 1'b1);

        // Random valid/tready
        sent = 0;
        cyc  = 0;
        while (sent < 20 && cyc < 500) begin
            @(posedge clk);
            #1;
            if (valid_in && ready_out) sent++;
            valid_in      = 1'($urandom_range(0, 1));
            data_in       = $urandom;
            last_in       = ($urandom_range(0, 3) == 0);
            m_axis_tready = 1'($urandom_range(0, 1));
            cyc++;
        end
        chk("random_sent", 64'(sent >= 20), 64'd1);
        drive(1'b0, '0, 1'b0, 1'b1);
        repeat (D + 2) drive(1'b0, '0, 1'b0, 1'b1);

        // Mid-packet reset with a push attempted during reset
        for (int i = 0; i < 3; i++) drive(1'b1, W'(32'h70 + i), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1; valid_in = 1'b1; data_in = 32'h99; last_in = 1'b0; m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; valid_in = 1'b0; m_axis_tready = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        drive(1'b1, 32'h55, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_rst_head", 64'(m_axis_tdata), 64'h55);
        repeat (4) drive(1'b0, '0, 1'b0, 1'b1);

        @(negedge clk);
        chk("drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
